// File: rtl/matrix_ls_fu.sv
// Matrix load/store functional unit: takes one issued LD/ST op, presents a single
// scratchpad request, waits for completion (or timeout) and reports done/err.
module matrix_ls_fu #(
    parameter int ADDR_W  = 32,
    parameter int IMM_W   = 11,
    parameter int MREG_W  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              fu_en,
    input  logic              mem_type,
    input  logic [MREG_W-1:0] rd,
    input  logic [ADDR_W-1:0] rdat1,
    input  logic [ADDR_W-1:0] rdat2,
    input  logic [IMM_W-1:0]  imm,
    input  logic              flush,
    input  logic              sp_ready,
    input  logic              sp_done,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        ls_out,
    output logic [MREG_W-1:0] rd_out,
    output logic [IMM_W-1:0]  imm_out,
    output logic [ADDR_W-1:0] address,
    output logic [ADDR_W-1:0] stride_out
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [ADDR_W-1:0] sext_imm(input logic [IMM_W-1:0] v);
        return {{(ADDR_W - IMM_W){v[IMM_W-1]}}, v};
    endfunction

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               err_r, err_s;
    logic [1:0]         ls_r, ls_s;
    logic [MREG_W-1:0]  rd_r, rd_s;
    logic [IMM_W-1:0]   imm_r, imm_s;
    logic [ADDR_W-1:0]  addr_r, addr_s;
    logic [ADDR_W-1:0]  stride_r, stride_s;

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        done_s   = 1'b0;
        err_s    = 1'b0;
        ls_s     = 2'b00;
        rd_s     = rd_r;
        imm_s    = imm_r;
        addr_s   = addr_r;
        stride_s = stride_r;
        case (state_r)
            ST_IDLE: begin
                if (fu_en && !flush) begin
                    state_s  = ST_REQ;
                    ls_s     = mem_type ? 2'b10 : 2'b01;
                    rd_s     = rd;
                    imm_s    = imm;
                    addr_s   = rdat1 + sext_imm(imm);
                    stride_s = rdat2;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                // An accepted request is already committed, so accept beats flush.
                if (sp_ready) begin
                    if (sp_done) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = {CNT_W{1'b0}};
                    end
                end else if (flush) begin
                    state_s = ST_IDLE;
                end else begin
                    ls_s = ls_r;
                end
            end
            ST_WAIT: begin
                if (sp_done) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_IDLE;
                    err_s   = 1'b1;
                end else begin
                    cnt_s = cnt_r + {{(CNT_W - 1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State, wait counter and output registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            ls_r     <= 2'b00;
            rd_r     <= {MREG_W{1'b0}};
            imm_r    <= {IMM_W{1'b0}};
            addr_r   <= {ADDR_W{1'b0}};
            stride_r <= {ADDR_W{1'b0}};
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            err_r    <= err_s;
            ls_r     <= ls_s;
            rd_r     <= rd_s;
            imm_r    <= imm_s;
            addr_r   <= addr_s;
            stride_r <= stride_s;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign ls_out     = ls_r;
    assign rd_out     = rd_r;
    assign imm_out    = imm_r;
    assign address    = addr_r;
    assign stride_out = stride_r;

endmodule
